// File: rtl/shared_adder_sched_if.sv
// Handshake bundle for the shared adder sequencer: two request ports,
// one tagged result port and a busy status.
interface shared_adder_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id, busy
    );
endinterface

// File: rtl/shared_adder_sched.sv
// Round-robin arbiter and nibble-serial sequencer sharing one 4-bit ripple
// carry adder between two requesters; one WIDTH-bit add takes WIDTH/4 cycles.

module ripple_carry_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic c;

    // NOTE: blocking '=' in combinational logic lets the carry ripple through the loop in order.
    always_comb begin
        c   = c_i;
        s_o = '0;
        for (int i = 0; i < 4; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        c_o = c;
    end
endmodule

module shared_adder_sched #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_adder_sched_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             id_q, id_d;
    logic             ptr_q, ptr_d;
    logic [KW-1:0]    k_q, k_d;

    logic             grant;
    logic             accept;
    logic [3:0]       a_nib, b_nib, s_nib;
    logic             c_nib;

    // With both requesters valid the pointer decides; otherwise the lone valid one wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) grant = ptr_q;
        else                                  grant = bus.req1_valid;
    end

    assign bus.req0_ready = (state_q == IDLE) && !rst && bus.req0_valid && !grant;
    assign bus.req1_ready = (state_q == IDLE) && !rst && bus.req1_valid &&  grant;
    assign accept         = bus.req0_ready | bus.req1_ready;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    ripple_carry_adder u_rca (
        .a_i (a_nib),
        .b_i (b_nib),
        .c_i (carry_q),
        .s_o (s_nib),
        .c_o (c_nib)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        k_d     = k_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant ? bus.req1_a   : bus.req0_a;
                    b_d     = grant ? bus.req1_b   : bus.req0_b;
                    carry_d = grant ? bus.req1_cin : bus.req0_cin;
                    id_d    = grant;
                    ptr_d   = ~grant;
                    k_d     = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < N; i++) begin
                    if (k_q == KW'(i)) sum_d[4*i +: 4] = s_nib;
                end
                carry_d = c_nib;
                if (k_q == KW'(N - 1)) begin
                    cout_d  = c_nib;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            k_q     <= k_d;
        end
    end

    // NOTE: operand registers have no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.res_valid = (state_q == DONE);
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign bus.res_id    = id_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_shared_adder_sched.sv
// Self-checking bench for shared_adder_sched: directed vectors at WIDTH=16 and 4,
// arbitration/hold/abort sequences, and a randomized run against a transaction model.
module tb_shared_adder_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16, rst4;

    shared_adder_sched_if #(.WIDTH(16)) bus16 ();
    shared_adder_sched_if #(.WIDTH(4))  bus4 ();

    shared_adder_sched #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16.slave));
    shared_adder_sched #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst4),  .bus(bus4.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        bit          cin;
        logic [15:0] sum;
        bit          cout;
    } vec16_t;

    typedef struct {
        bit          id;
        logic [3:0]  a;
        logic [3:0]  b;
        bit          cin;
        logic [3:0]  sum;
        bit          cout;
    } vec4_t;

    vec16_t vt16[7];
    vec4_t  vt4[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive16(input bit id, input logic [15:0] a, input logic [15:0] b, input bit cin);
        if (id) begin
            bus16.req1_valid = 1'b1; bus16.req1_a = a; bus16.req1_b = b; bus16.req1_cin = cin;
        end else begin
            bus16.req0_valid = 1'b1; bus16.req0_a = a; bus16.req0_b = b; bus16.req0_cin = cin;
        end
    endtask

    task automatic drain16(input string tag);
        int w;
        w = 0;
        bus16.res_ready  = 1'b1;
        bus16.req0_valid = 1'b0;
        bus16.req1_valid = 1'b0;
        while (bus16.busy && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_drain"}, bus16.busy, 1'b0);
    endtask

    task automatic run_op16(input bit id, input logic [15:0] a, input logic [15:0] b, input bit cin,
                            input logic [15:0] es, input bit ec, input string tag);
        int w;
        int lat;
        @(posedge clk); #1;
        bus16.res_ready = 1'b1;
        drive16(id, a, b, cin);
        w = 0;
        #1;
        while (!(id ? bus16.req1_ready : bus16.req0_ready) && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        check({tag, "_accept"}, w < 20, 1'b1);
        @(posedge clk); #1;
        bus16.req0_valid = 1'b0;
        bus16.req1_valid = 1'b0;
        lat = 1;
        while (!bus16.res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_sum"}, bus16.res_sum, es);
        check({tag, "_cout"}, bus16.res_cout, ec);
        check({tag, "_id"}, bus16.res_id, id);
        @(posedge clk); #1;
        check({tag, "_idle"}, {bus16.busy, bus16.res_valid}, 2'b00);
    endtask

    task automatic run_op4(input bit id, input logic [3:0] a, input logic [3:0] b, input bit cin,
                           input logic [3:0] es, input bit ec, input string tag);
        int w;
        int lat;
        @(posedge clk); #1;
        bus4.res_ready = 1'b1;
        if (id) begin
            bus4.req1_valid = 1'b1; bus4.req1_a = a; bus4.req1_b = b; bus4.req1_cin = cin;
        end else begin
            bus4.req0_valid = 1'b1; bus4.req0_a = a; bus4.req0_b = b; bus4.req0_cin = cin;
        end
        w = 0;
        #1;
        while (!(id ? bus4.req1_ready : bus4.req0_ready) && w < 20) begin
            @(posedge clk); #2;
            w++;
        end
        check({tag, "_accept"}, w < 20, 1'b1);
        @(posedge clk); #1;
        bus4.req0_valid = 1'b0;
        bus4.req1_valid = 1'b0;
        lat = 1;
        while (!bus4.res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_sum"}, bus4.res_sum, es);
        check({tag, "_cout"}, bus4.res_cout, ec);
        check({tag, "_id"}, bus4.res_id, id);
        @(posedge clk); #1;
        check({tag, "_idle"}, {bus4.busy, bus4.res_valid}, 2'b00);
    endtask

    // Randomized-run model state: one transaction in flight, round-robin on ties.
    bit          pend[2];
    logic [15:0] ra[2], rb[2];
    bit          rc[2];
    bit          in_flight, acc_prev, hs_prev, rr, allow, gv, g, both_hi, seen;
    int          lat_m, n_acc, n_res, w;
    logic [16:0] exp_res;
    bit          exp_id;
    int          gq[$], cq[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt16[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0};
        vt16[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt16[2] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt16[3] = '{1'b1, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vt16[4] = '{1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vt16[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt16[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt4[0]  = '{1'b0, 4'h9, 4'h8, 1'b1, 4'h2, 1'b1};
        vt4[1]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
        vt4[2]  = '{1'b0, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0};

        rst16 = 1'b1;
        rst4  = 1'b1;
        bus4.req0_valid = 1'b0; bus4.req1_valid = 1'b0; bus4.res_ready = 1'b1;
        bus4.req0_a = '0; bus4.req0_b = '0; bus4.req0_cin = 1'b0;
        bus4.req1_a = '0; bus4.req1_b = '0; bus4.req1_cin = 1'b0;
        bus16.res_ready = 1'b1;
        drive16(1'b0, 16'h0101, 16'h0202, 1'b0);
        drive16(1'b1, 16'h0303, 16'h0404, 1'b1);

        // Reset state, with both requesters already valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready0", bus16.req0_ready, 1'b0);
        check("rst_ready1", bus16.req1_ready, 1'b0);
        check("rst_busy", bus16.busy, 1'b0);
        check("rst_res_valid", bus16.res_valid, 1'b0);
        check("rst_sum", bus16.res_sum, 16'h0000);
        check("rst_cout_id", {bus16.res_cout, bus16.res_id}, 2'b00);
        rst16 = 1'b0;
        rst4  = 1'b0;

        // Both valid continuously: grants alternate starting with requester 0, 6 cycles apart.
        both_hi = 1'b0;
        #1;
        for (int c = 0; c < 24; c++) begin
            if (bus16.req0_ready && bus16.req1_ready) both_hi = 1'b1;
            if (bus16.req0_ready) begin gq.push_back(0); cq.push_back(c); end
            else if (bus16.req1_ready) begin gq.push_back(1); cq.push_back(c); end
            @(posedge clk); #2;
        end
        drain16("rr");
        check("rr_both_ready", both_hi, 1'b0);
        check("rr_grant_count", gq.size(), 4);
        if (gq.size() >= 4) begin
            check("rr_first_cycle", cq[0], 0);
            for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), gq[i], i % 2);
            for (int i = 1; i < 4; i++) check($sformatf("rr_spacing%0d", i), cq[i] - cq[i-1], 6);
        end

        for (int i = 0; i < 7; i++)
            run_op16(vt16[i].id, vt16[i].a, vt16[i].b, vt16[i].cin, vt16[i].sum, vt16[i].cout,
                     $sformatf("vec16_%0d", i));

        // Result held in DONE while the consumer stalls.
        @(posedge clk); #1;
        bus16.res_ready = 1'b0;
        drive16(1'b0, 16'h1234, 16'h0FCD, 1'b0);
        #1;
        check("hold_accept", bus16.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus16.req0_valid = 1'b0;
        w = 0;
        while (!bus16.res_valid && w < 20) begin @(posedge clk); #1; w++; end
        check("hold_reach", bus16.res_valid, 1'b1);
        drive16(1'b0, 16'h5555, 16'h5555, 1'b1);
        drive16(1'b1, 16'hAAAA, 16'h5555, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold_valid", bus16.res_valid, 1'b1);
            check("hold_sum", bus16.res_sum, 16'h2201);
            check("hold_cout_id", {bus16.res_cout, bus16.res_id}, 2'b00);
            check("hold_busy", bus16.busy, 1'b1);
            check("hold_readies", {bus16.req0_ready, bus16.req1_ready}, 2'b00);
            @(posedge clk); #1;
        end
        bus16.res_ready  = 1'b1;
        bus16.req0_valid = 1'b0;
        bus16.req1_valid = 1'b0;
        #1;
        check("hold_release_valid", bus16.res_valid, 1'b1);
        @(posedge clk); #1;
        check("hold_after_hs", {bus16.busy, bus16.res_valid}, 2'b00);
        @(posedge clk); #1;
        check("hold_single_hs", bus16.res_valid, 1'b0);

        // Reset in the second ADD cycle aborts the operation.
        run_op16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "pre_abort");
        @(posedge clk); #1;
        drive16(1'b0, 16'h1111, 16'h1111, 1'b0);
        #1;
        check("abort_accept", bus16.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus16.req0_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_add", bus16.busy, 1'b1);
        rst16 = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", bus16.busy, 1'b0);
        check("abort_res_valid", bus16.res_valid, 1'b0);
        check("abort_sum", bus16.res_sum, 16'h0000);
        check("abort_cout_id", {bus16.res_cout, bus16.res_id}, 2'b00);
        rst16 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus16.res_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 1'b0);
        run_op16(1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "post_abort");

        for (int i = 0; i < 3; i++)
            run_op4(vt4[i].id, vt4[i].a, vt4[i].b, vt4[i].cin, vt4[i].sum, vt4[i].cout,
                    $sformatf("vec4_%0d", i));

        // Randomized traffic against the transaction-level model.
        @(posedge clk); #1;
        rst16 = 1'b1;
        @(posedge clk); #1;
        rst16 = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        in_flight = 1'b0; acc_prev = 1'b0; hs_prev = 1'b0; rr = 1'b0;
        lat_m = 0; n_acc = 0; n_res = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            allow = (cyc < 1500);
            @(posedge clk); #1;
            if (hs_prev) in_flight = 1'b0;
            if (acc_prev) begin in_flight = 1'b1; lat_m = 0; end
            hs_prev  = 1'b0;
            acc_prev = 1'b0;
            if (in_flight) lat_m++;
            check("rnd_busy", bus16.busy, in_flight);
            check("rnd_res_valid", bus16.res_valid, in_flight && lat_m >= 5);
            if (bus16.res_valid && in_flight && lat_m >= 5) begin
                check("rnd_sum", bus16.res_sum, exp_res[15:0]);
                check("rnd_cout", bus16.res_cout, exp_res[16]);
                check("rnd_id", bus16.res_id, exp_id);
            end
            bus16.res_ready = allow ? 1'($urandom) : 1'b1;
            if (in_flight && lat_m >= 5 && bus16.res_ready) begin hs_prev = 1'b1; n_res++; end
            for (int x = 0; x < 2; x++) begin
                if (!pend[x] && allow && ($urandom % 4 == 0)) begin
                    pend[x] = 1'b1;
                    ra[x]   = 16'($urandom);
                    rb[x]   = 16'($urandom);
                    rc[x]   = 1'($urandom);
                end
            end
            bus16.req0_valid = pend[0]; bus16.req0_a = ra[0]; bus16.req0_b = rb[0]; bus16.req0_cin = rc[0];
            bus16.req1_valid = pend[1]; bus16.req1_a = ra[1]; bus16.req1_b = rb[1]; bus16.req1_cin = rc[1];
            #1;
            gv = !in_flight && (pend[0] || pend[1]);
            g  = (pend[0] && pend[1]) ? rr : pend[1];
            check("rnd_ready0", bus16.req0_ready, gv && !g);
            check("rnd_ready1", bus16.req1_ready, gv && g);
            if (gv) begin
                acc_prev = 1'b1;
                n_acc++;
                exp_res  = {1'b0, ra[g]} + {1'b0, rb[g]} + 17'(rc[g]);
                exp_id   = g;
                rr       = !g;
                pend[g]  = 1'b0;
            end
        end
        check("rnd_all_served", {in_flight, pend[0], pend[1]}, 3'b000);
        check("rnd_result_count", n_res, n_acc);
        check("rnd_traffic", n_acc > 50, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
